// File: rtl/ppu_oam_dma.sv
// OAM DMA engine: copies a 160-byte source page into the PPU's
// 16-bit OAM, one byte per M-cycle, packing byte pairs into words.
module ppu_oam_dma #(
  parameter int BYTES           = 160,
  parameter int CYCLES_PER_BYTE = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_reg_write,
  input  logic [7:0]  i_reg_d_wr,
  output logic [7:0]  o_reg_d_rd,
  output logic        o_dma_active,
  output logic [15:0] o_dma_src_addr,
  input  logic [7:0]  i_dma_d_in,
  output logic [6:0]  o_oam_addr,
  output logic [15:0] o_oam_d_wr,
  output logic        o_oam_write
);

  localparam int PW =
    (CYCLES_PER_BYTE > 1) ? $clog2(CYCLES_PER_BYTE) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(CYCLES_PER_BYTE - 1);
  localparam logic [7:0]    B_LAST  = 8'(BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_XFER,
    S_FLUSH
  } state_t;

  state_t        r_state, w_state_n;
  logic [PW-1:0] r_phase, w_phase_n;
  logic [7:0]    r_byte_idx, w_idx_n;
  logic [7:0]    r_page, w_page_n;
  logic [7:0]    r_low, w_low_n;
  logic [7:0]    r_reg_d_rd, w_rd_n;
  logic          r_oam_write, w_wr_n;
  logic [6:0]    r_oam_addr, w_oaddr_n;
  logic [15:0]   r_oam_d_wr, w_odata_n;
  logic [7:0]    w_page_eff;

  // Echo RAM pages E0-FF fold back onto C0-DF.
  assign w_page_eff = (r_page >= 8'hE0) ? (r_page - 8'h20) : r_page;

  assign o_reg_d_rd     = r_reg_d_rd;
  assign o_dma_src_addr = {w_page_eff, r_byte_idx};
  assign o_dma_active   = (r_state == S_XFER) || (r_state == S_FLUSH);
  assign o_oam_addr     = r_oam_addr;
  assign o_oam_d_wr     = r_oam_d_wr;
  assign o_oam_write    = r_oam_write;

  // Next-state: a register write restarts from any state.
  always_comb begin
    w_state_n = r_state;
    w_phase_n = r_phase;
    w_idx_n   = r_byte_idx;
    w_page_n  = r_page;
    w_low_n   = r_low;
    w_rd_n    = r_reg_d_rd;
    w_wr_n    = 1'b0;
    w_oaddr_n = r_oam_addr;
    w_odata_n = r_oam_d_wr;
    if (i_reg_write) begin
      w_state_n = S_START;
      w_phase_n = '0;
      w_idx_n   = 8'h00;
      w_page_n  = i_reg_d_wr;
      w_rd_n    = i_reg_d_wr;
      w_low_n   = 8'h00;
    end else begin
      unique case (r_state)
        S_IDLE: begin
        end
        S_START: begin
          if (r_phase == PH_LAST) begin
            w_state_n = S_XFER;
            w_phase_n = '0;
            w_idx_n   = 8'h00;
          end else begin
            w_phase_n = r_phase + 1'b1;
          end
        end
        S_XFER: begin
          if (r_phase == PH_LAST) begin
            w_phase_n = '0;
            if (!r_byte_idx[0]) begin
              w_low_n = i_dma_d_in;
            end else begin
              w_wr_n    = 1'b1;
              w_oaddr_n = r_byte_idx[7:1];
              w_odata_n = {i_dma_d_in, r_low};
            end
            if (r_byte_idx == B_LAST) begin
              w_state_n = S_FLUSH;
            end else begin
              w_idx_n = r_byte_idx + 8'h01;
            end
          end else begin
            w_phase_n = r_phase + 1'b1;
          end
        end
        S_FLUSH: begin
          w_state_n = S_IDLE;
          w_idx_n   = 8'h00;
        end
        default: begin
          w_state_n = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_phase     <= '0;
      r_byte_idx  <= 8'h00;
      r_page      <= 8'h00;
      r_low       <= 8'h00;
      r_reg_d_rd  <= 8'hFF;
      r_oam_write <= 1'b0;
      r_oam_addr  <= 7'h00;
      r_oam_d_wr  <= 16'h0000;
    end else begin
      r_state     <= w_state_n;
      r_phase     <= w_phase_n;
      r_byte_idx  <= w_idx_n;
      r_page      <= w_page_n;
      r_low       <= w_low_n;
      r_reg_d_rd  <= w_rd_n;
      r_oam_write <= w_wr_n;
      r_oam_addr  <= w_oaddr_n;
      r_oam_d_wr  <= w_odata_n;
    end
  end

endmodule
